uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
Round-robin arbiter that shares the single UART transmit port (tx data / strobe / busy) of the UART controller between NREQ requesters, e.g. the sequencer result path and a status/echo path.
Requesters push words through a valid/ready handshake. A requester may lock the port for a multi-word packet, marked by a last flag.
The block sequences each word: strobe, wait for busy to rise, wait for busy to fall. It sits between the requesters and the UART controller in the top level.

Parameters:
NREQ, 2, number of requesters (2..8)
DW, 8, transmit data width
BUSY_WAIT, 16, max cycles to wait for i_tx_busy to rise after a strobe before treating the word as sent

Ports:
clk  in  1  system clock (100MHz)
rst  in  1  reset; asynchronous, active-high
i_req_valid  in  NREQ  per-requester word valid
i_req_data  in  NREQ*DW  per-requester word; requester k uses bits [k*DW +: DW]
i_req_last  in  NREQ  per-requester last-word-of-packet flag, qualified by valid
o_req_ready  out  NREQ  one-hot accept; a word transfers when valid and ready are both high
o_tx_data  out  DW  data to UART controller
o_tx_stb  out  1  one-cycle transmit strobe to UART controller
i_tx_busy  in  1  UART controller busy
o_grant  out  NREQ  one-hot current owner; all zero when idle
o_active  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async assert, sync deassert by the clock domain):
  - state=IDLE; o_req_ready=0, o_tx_stb=0, o_tx_data=0, o_grant=0, o_active=0.
  - RR pointer=NREQ-1, so requester 0 has highest priority first.
- States: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE: if any i_req_valid and !i_tx_busy:
  - select winner by scanning ptr+1, ptr+2, ... with modulo-NREQ wrap.
  - register winner into o_grant; next state SEND.
  - Otherwise stay in IDLE.
- SEND:
  - o_req_ready[owner] = i_req_valid[owner] & !i_tx_busy (combinational); all other ready bits are 0.
  - On acceptance: capture data into o_tx_data, capture last into last_q, assert o_tx_stb on the next cycle for exactly 1 cycle, clear the wait counter, go to WAIT_HI.
  - If the owner's valid is low, hold in SEND and keep the grant (packet lock). No other requester is served meanwhile.
- WAIT_HI:
  - Go to WAIT_LO when i_tx_busy=1.
  - Also go to WAIT_LO when the wait counter reaches BUSY_WAIT-1 (timeout).
  - Counter increments each cycle in this state; width is clog2(BUSY_WAIT)+1.
- WAIT_LO: when i_tx_busy=0:
  - if last_q=1: ptr<=owner, o_grant<=0, next state IDLE.
  - else: next state SEND, same owner.
- Latency, idle to strobe:
  - valid seen in IDLE at cycle t; grant and ready at t+1; o_tx_stb at t+2.
  - Minimum idle gap between packets: 1 cycle in IDLE.
- o_tx_data holds its value until the next acceptance.
- i_req_data and i_req_last are ignored when not accepted.
- Simultaneous requests: the lowest index after ptr wins; a requester never waits more than NREQ-1 packets.
- i_tx_busy high in IDLE: no grant is issued.
- i_tx_busy high in SEND: ready is held low.
- Valid dropped while in WAIT_*: no effect; the word was already accepted.
- Reset mid-packet: everything returns to reset values immediately; the packet is abandoned and any strobe is cancelled.
- Single-word packets: a requester drives last=1 with every word.

Test Plan:
- NREQ=2, req0 sends 0x41 with last=1, busy rises 1 cycle after stb and lasts 10 cycles.
  -> ready0 at t+1, stb with data 0x41 at t+2, grant returns to 0 the cycle after busy falls.
- req0 and req1 both valid with last=1 in the same cycle after reset.
  -> 0x10 from req0 is sent first, then 0x20 from req1.
  -> a following simultaneous pair again serves req0 first (ptr=1 wraps to 0).
- req1 sends a 3-word packet 0xA1,0xA2,0xA3 (last on 0xA3) while req0 is held valid.
  -> three strobes in order with grant=2'b10 throughout; req0 is served only after 0xA3 completes.
- BUSY_WAIT=4, i_tx_busy stuck low after a strobe.
  -> state leaves WAIT_HI after 4 cycles; the word completes and the grant is released.
- rst asserted asynchronously (mid-cycle) during WAIT_LO of word 2 of a 3-word packet.
  -> all outputs 0 immediately; after release, a new req0 word 0x55 is sent normally.
- NREQ=3, all three requesters continuously valid with last=1.
  -> grant sequence 0,1,2,0,1,2 with no starvation.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmit port between NREQ requesters.
// Each word is sent as: strobe, wait for busy to rise (or timeout), wait for busy to fall.
module uart_tx_arb #(
  parameter int NREQ      = 2,
  parameter int DW        = 8,
  parameter int BUSY_WAIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*DW-1:0] i_req_data,
  input  logic [NREQ-1:0]    i_req_last,
  output logic [NREQ-1:0]    o_req_ready,
  output logic [DW-1:0]      o_tx_data,
  output logic               o_tx_stb,
  input  logic               i_tx_busy,
  output logic [NREQ-1:0]    o_grant,
  output logic               o_active
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(BUSY_WAIT) + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            tx_stb_q, tx_stb_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [PW-1:0]   win_idx;
  logic [DW-1:0]   own_data;
  logic            own_valid;
  logic            own_last;
  logic            accept;

  // Scan ptr+1, ptr+2, ... with wrap; iterating from the far end lets the nearest hit win.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [PW-1:0]   ptr);
    logic [PW:0]   sum;
    logic [PW-1:0] pick;
    pick = ptr;
    for (int i = NREQ; i >= 1; i--) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (req[sum[PW-1:0]]) pick = sum[PW-1:0];
    end
    return pick;
  endfunction

  assign win_idx   = rr_pick(i_req_valid, ptr_q);
  assign own_valid = i_req_valid[owner_q];
  assign own_last  = i_req_last[owner_q];
  assign accept    = (state_q == SEND) && own_valid && !i_tx_busy;

  always_comb begin
    own_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q == PW'(k)) own_data = i_req_data[k*DW +: DW];
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    tx_stb_d  = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (|i_req_valid && !i_tx_busy) begin
          owner_d = win_idx;
          grant_d = NREQ'(1) << win_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          tx_data_d = own_data;
          last_d    = own_last;
          tx_stb_d  = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        cnt_d = cnt_q + 1'b1;
        // A controller that never raises busy must not hang the port.
        if (i_tx_busy || cnt_q == CW'(BUSY_WAIT - 1)) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!i_tx_busy) begin
          if (last_q) begin
            ptr_d   = owner_q;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PW'(NREQ - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      tx_stb_q  <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      tx_stb_q  <= tx_stb_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  // Grant is one-hot on the owner, so it doubles as the ready mask.
  assign o_req_ready = accept ? grant_q : '0;
  assign o_tx_data   = tx_data_q;
  assign o_tx_stb    = tx_stb_q;
  assign o_grant     = grant_q;
  assign o_active    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: cycle table on a 2-requester instance, plus
// hand sequences for the busy timeout (BUSY_WAIT=4) and 3-way rotation.
module tb_uart_tx_arb;

  logic        clk;
  logic        rst;

  logic [1:0]  valid2, last2, rdy2, gnt2;
  logic [15:0] data2;
  logic        busy2, stb2, act2;
  logic [7:0]  txd2;

  logic [1:0]  valid_to, last_to, rdy_to, gnt_to;
  logic [15:0] data_to;
  logic        busy_to, stb_to, act_to;
  logic [7:0]  txd_to;

  logic [2:0]  valid3, last3, rdy3, gnt3;
  logic [23:0] data3;
  logic        busy3, stb3, act3;
  logic [7:0]  txd3;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         n;
    logic       rst;
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] last;
    logic       busy;
    logic [1:0] rdy;
    logic       stb;
    logic [7:0] dat;
    logic [1:0] gnt;
    logic       act;
  } vec_t;

  vec_t vt[$];

  uart_tx_arb #(.NREQ(2), .DW(8), .BUSY_WAIT(16)) u_dut2 (
    .clk(clk), .rst(rst),
    .i_req_valid(valid2), .i_req_data(data2), .i_req_last(last2),
    .o_req_ready(rdy2), .o_tx_data(txd2), .o_tx_stb(stb2), .i_tx_busy(busy2),
    .o_grant(gnt2), .o_active(act2)
  );

  uart_tx_arb #(.NREQ(2), .DW(8), .BUSY_WAIT(4)) u_dut_to (
    .clk(clk), .rst(rst),
    .i_req_valid(valid_to), .i_req_data(data_to), .i_req_last(last_to),
    .o_req_ready(rdy_to), .o_tx_data(txd_to), .o_tx_stb(stb_to), .i_tx_busy(busy_to),
    .o_grant(gnt_to), .o_active(act_to)
  );

  uart_tx_arb #(.NREQ(3), .DW(8), .BUSY_WAIT(16)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req_valid(valid3), .i_req_data(data3), .i_req_last(last3),
    .o_req_ready(rdy3), .o_tx_data(txd3), .o_tx_stb(stb3), .i_tx_busy(busy3),
    .o_grant(gnt3), .o_active(act3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic row(input int n, input logic r, input logic [1:0] v,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] l,
                     input logic b, input logic [1:0] erdy, input logic estb,
                     input logic [7:0] edat, input logic [1:0] egnt, input logic eact);
    vec_t e;
    e.n = n; e.rst = r; e.valid = v; e.d0 = d0; e.d1 = d1; e.last = l; e.busy = b;
    e.rdy = erdy; e.stb = estb; e.dat = edat; e.gnt = egnt; e.act = eact;
    vt.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic       seen;
    logic [7:0] ed;

    rst = 1'b1;
    valid2 = '0; data2 = '0; last2 = '0; busy2 = 1'b0;
    valid_to = '0; data_to = '0; last_to = '0; busy_to = 1'b0;
    valid3 = '0; data3 = '0; last3 = '0; busy3 = 1'b0;

    //   n rst valid  d0     d1     last  busy | rdy   stb dat    gnt   act
    // reset state
    row( 2, 1, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h00, 2'b00, 0);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h00, 2'b00, 0);
    // single word 0x41 from req0, busy 10 cycles
    row( 1, 0, 2'b01, 8'h41, 8'h00, 2'b01, 0,   2'b00, 0, 8'h00, 2'b00, 0);
    row( 1, 0, 2'b01, 8'h41, 8'h00, 2'b01, 0,   2'b01, 0, 8'h00, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 1, 8'h41, 2'b01, 1);
    row(10, 0, 2'b00, 8'h00, 8'h00, 2'b00, 1,   2'b00, 0, 8'h41, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h41, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h41, 2'b00, 0);
    // fresh reset, simultaneous pair 0x10/0x20
    row( 2, 1, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h00, 2'b00, 0);
    row( 1, 0, 2'b11, 8'h10, 8'h20, 2'b11, 0,   2'b00, 0, 8'h00, 2'b00, 0);
    row( 1, 0, 2'b11, 8'h10, 8'h20, 2'b11, 0,   2'b01, 0, 8'h00, 2'b01, 1);
    row( 1, 0, 2'b10, 8'h10, 8'h20, 2'b11, 0,   2'b00, 1, 8'h10, 2'b01, 1);
    row( 2, 0, 2'b10, 8'h10, 8'h20, 2'b11, 1,   2'b00, 0, 8'h10, 2'b01, 1);
    row( 1, 0, 2'b10, 8'h10, 8'h20, 2'b11, 0,   2'b00, 0, 8'h10, 2'b01, 1);
    row( 1, 0, 2'b10, 8'h10, 8'h20, 2'b11, 0,   2'b00, 0, 8'h10, 2'b00, 0);
    row( 1, 0, 2'b10, 8'h10, 8'h20, 2'b11, 0,   2'b10, 0, 8'h10, 2'b10, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 1, 8'h20, 2'b10, 1);
    row( 2, 0, 2'b00, 8'h00, 8'h00, 2'b00, 1,   2'b00, 0, 8'h20, 2'b10, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h20, 2'b10, 1);
    // second pair: pointer wraps, req0 first again
    row( 1, 0, 2'b11, 8'h30, 8'h40, 2'b11, 0,   2'b00, 0, 8'h20, 2'b00, 0);
    row( 1, 0, 2'b11, 8'h30, 8'h40, 2'b11, 0,   2'b01, 0, 8'h20, 2'b01, 1);
    row( 1, 0, 2'b10, 8'h30, 8'h40, 2'b11, 0,   2'b00, 1, 8'h30, 2'b01, 1);
    row( 1, 0, 2'b10, 8'h30, 8'h40, 2'b11, 1,   2'b00, 0, 8'h30, 2'b01, 1);
    row( 1, 0, 2'b10, 8'h30, 8'h40, 2'b11, 0,   2'b00, 0, 8'h30, 2'b01, 1);
    // busy high in IDLE blocks the grant, busy high in SEND holds ready low
    row( 3, 0, 2'b10, 8'h30, 8'h40, 2'b11, 1,   2'b00, 0, 8'h30, 2'b00, 0);
    row( 1, 0, 2'b10, 8'h30, 8'h40, 2'b11, 0,   2'b00, 0, 8'h30, 2'b00, 0);
    row( 2, 0, 2'b10, 8'h30, 8'h40, 2'b11, 1,   2'b00, 0, 8'h30, 2'b10, 1);
    row( 1, 0, 2'b10, 8'h30, 8'h40, 2'b11, 0,   2'b10, 0, 8'h30, 2'b10, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 1, 8'h40, 2'b10, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 1,   2'b00, 0, 8'h40, 2'b10, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h40, 2'b10, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h40, 2'b00, 0);
    // req1 3-word packet A1,A2,A3 locks out req0 (valid from the second cycle)
    row( 1, 0, 2'b10, 8'h00, 8'hA1, 2'b00, 0,   2'b00, 0, 8'h40, 2'b00, 0);
    row( 1, 0, 2'b11, 8'h5A, 8'hA1, 2'b01, 0,   2'b10, 0, 8'h40, 2'b10, 1);
    row( 1, 0, 2'b11, 8'h5A, 8'hA2, 2'b01, 0,   2'b00, 1, 8'hA1, 2'b10, 1);
    row( 1, 0, 2'b11, 8'h5A, 8'hA2, 2'b01, 1,   2'b00, 0, 8'hA1, 2'b10, 1);
    row( 1, 0, 2'b11, 8'h5A, 8'hA2, 2'b01, 0,   2'b00, 0, 8'hA1, 2'b10, 1);
    row( 1, 0, 2'b11, 8'h5A, 8'hA2, 2'b01, 0,   2'b10, 0, 8'hA1, 2'b10, 1);
    row( 1, 0, 2'b01, 8'h5A, 8'h00, 2'b01, 0,   2'b00, 1, 8'hA2, 2'b10, 1);
    row( 1, 0, 2'b01, 8'h5A, 8'h00, 2'b01, 1,   2'b00, 0, 8'hA2, 2'b10, 1);
    row( 1, 0, 2'b01, 8'h5A, 8'h00, 2'b01, 0,   2'b00, 0, 8'hA2, 2'b10, 1);
    row( 2, 0, 2'b01, 8'h5A, 8'h00, 2'b01, 0,   2'b00, 0, 8'hA2, 2'b10, 1);
    row( 1, 0, 2'b11, 8'h5A, 8'hA3, 2'b11, 0,   2'b10, 0, 8'hA2, 2'b10, 1);
    row( 1, 0, 2'b01, 8'h5A, 8'h00, 2'b01, 0,   2'b00, 1, 8'hA3, 2'b10, 1);
    row( 1, 0, 2'b01, 8'h5A, 8'h00, 2'b01, 1,   2'b00, 0, 8'hA3, 2'b10, 1);
    row( 1, 0, 2'b01, 8'h5A, 8'h00, 2'b01, 0,   2'b00, 0, 8'hA3, 2'b10, 1);
    row( 1, 0, 2'b01, 8'h5A, 8'h00, 2'b01, 0,   2'b00, 0, 8'hA3, 2'b00, 0);
    row( 1, 0, 2'b01, 8'h5A, 8'h00, 2'b01, 0,   2'b01, 0, 8'hA3, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 1, 8'h5A, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 1,   2'b00, 0, 8'h5A, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h5A, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h5A, 2'b00, 0);
    // req0 3-word packet, reset mid-cycle during WAIT_LO of word 2, then 0x55
    row( 1, 0, 2'b01, 8'hC1, 8'h00, 2'b00, 0,   2'b00, 0, 8'h5A, 2'b00, 0);
    row( 1, 0, 2'b01, 8'hC1, 8'h00, 2'b00, 0,   2'b01, 0, 8'h5A, 2'b01, 1);
    row( 1, 0, 2'b01, 8'hC2, 8'h00, 2'b00, 0,   2'b00, 1, 8'hC1, 2'b01, 1);
    row( 1, 0, 2'b01, 8'hC2, 8'h00, 2'b00, 1,   2'b00, 0, 8'hC1, 2'b01, 1);
    row( 1, 0, 2'b01, 8'hC2, 8'h00, 2'b00, 0,   2'b00, 0, 8'hC1, 2'b01, 1);
    row( 1, 0, 2'b01, 8'hC2, 8'h00, 2'b00, 0,   2'b01, 0, 8'hC1, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 1, 8'hC2, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 1,   2'b00, 0, 8'hC2, 2'b01, 1);
    row( 2, 1, 2'b00, 8'h00, 8'h00, 2'b00, 1,   2'b00, 0, 8'h00, 2'b00, 0);
    row( 1, 0, 2'b01, 8'h55, 8'h00, 2'b01, 0,   2'b00, 0, 8'h00, 2'b00, 0);
    row( 1, 0, 2'b01, 8'h55, 8'h00, 2'b01, 0,   2'b01, 0, 8'h00, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 1, 8'h55, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 1,   2'b00, 0, 8'h55, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h55, 2'b01, 1);
    row( 1, 0, 2'b00, 8'h00, 8'h00, 2'b00, 0,   2'b00, 0, 8'h55, 2'b00, 0);

    foreach (vt[i]) begin
      for (int c = 0; c < vt[i].n; c++) begin
        @(negedge clk);
        rst    = vt[i].rst;
        valid2 = vt[i].valid;
        data2  = {vt[i].d1, vt[i].d0};
        last2  = vt[i].last;
        busy2  = vt[i].busy;
        #1;
        check($sformatf("row%0d.%0d {rdy,stb,dat,gnt,act}", i, c),
              {rdy2, stb2, txd2, gnt2, act2},
              {vt[i].rdy, vt[i].stb, vt[i].dat, vt[i].gnt, vt[i].act});
      end
    end

    // Busy never rises: WAIT_HI times out after 4 cycles, then the word completes.
    @(negedge clk);
    valid_to = 2'b01; data_to = 16'h0077; last_to = 2'b01; busy_to = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      if (stb_to) seen = 1'b1;
    end
    valid_to = 2'b00;
    check("to_stb_seen", seen, 1);
    check("to_data", txd_to, 8'h77);
    check("to_gnt_at_stb", {act_to, gnt_to}, 3'b101);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      if (k == 1) check("to_stb_one_cycle", stb_to, 0);
      if (k <= 4) check($sformatf("to_hold_%0d", k), {act_to, gnt_to}, 3'b101);
      else        check("to_release", {act_to, gnt_to}, 3'b000);
    end

    // Three requesters always valid: grants rotate 0,1,2,0,1,2.
    valid3 = 3'b111; last3 = 3'b111; data3 = {8'h32, 8'h31, 8'h30};
    for (int p = 0; p < 6; p++) begin
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk); #1;
        if (stb3) seen = 1'b1;
      end
      ed = 8'h30 + 8'(p % 3);
      check($sformatf("rr3_stb_seen_%0d", p), seen, 1);
      check($sformatf("rr3_grant_%0d", p), gnt3, 3'b001 << (p % 3));
      check($sformatf("rr3_data_%0d", p), txd3, ed);
      @(negedge clk); busy3 = 1'b1;
      @(negedge clk);
      @(negedge clk); busy3 = 1'b0;
    end
    valid3 = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
